// File: rtl/spi_trig_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_trig_seq
// Brief    : Counts qualified SPI pattern matches, fires a trigger on the Nth,
//            applies a holdoff, then re-arms or stops. Bus regs 0x74..0x88.
// Options  : SPI_SEQ_TIMEOUT_EN adds the forced auto-trigger timeout (0x88).
// Revision : 1.0 - initial release
// ============================================================================
module spi_trig_seq #(
    parameter int CNT_W  = 16,
    parameter int HOLD_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_ack,
    input  logic        trg_in,
    input  logic        trg_valid,
    output logic        trig_out,
    output logic        armed
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FIRE  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [19:0] c_ADDR_CTRL   = 20'h74;
    localparam logic [19:0] c_ADDR_MATCH  = 20'h78;
    localparam logic [19:0] c_ADDR_HOLD   = 20'h7C;
    localparam logic [19:0] c_ADDR_STATUS = 20'h80;
    localparam logic [19:0] c_ADDR_FIRES  = 20'h84;
    localparam logic [19:0] c_ADDR_TMO    = 20'h88;

    state_t            r_state, w_nextState;
    logic [CNT_W-1:0]  r_matchCfg, r_count, w_effCnt;
    logic [CNT_W:0]    w_cntInc;
    logic [HOLD_W-1:0] r_holdoff, r_holdCnt;
    logic              r_cont, r_consec, r_done, r_ack;
    logic [31:0]       r_fireCount, r_rdata, w_rdMux, w_cntExt;
    logic [19:0]       w_addr;
    logic              w_inRange, w_ctrlWr, w_arm, w_disarm, w_qual, w_reach;
    logic              w_tmoHit, w_fireByTmo, w_tmo, w_unused;

    assign w_addr    = sys_addr[19:0];
    assign w_inRange = (w_addr >= c_ADDR_CTRL) && (w_addr <= c_ADDR_TMO);
    assign w_ctrlWr  = sys_wen && (w_addr == c_ADDR_CTRL);
    // DISARM has priority over ARM when both bits are written together
    assign w_disarm  = w_ctrlWr && sys_wdata[1];
    assign w_arm     = w_ctrlWr && sys_wdata[0] && !sys_wdata[1];
    assign w_qual    = (r_state == S_ARMED) && trg_valid && trg_in;
    assign w_effCnt  = (r_matchCfg == '0) ? CNT_W'(1) : r_matchCfg;
    assign w_cntInc  = {1'b0, r_count} + (CNT_W+1)'(1);
    // >= so that lowering MATCH_CNT below the current count fires on the next match
    assign w_reach   = w_cntInc >= {1'b0, w_effCnt};
    assign w_cntExt  = 32'(r_count);

    assign trig_out  = (r_state == S_FIRE);
    assign armed     = (r_state == S_ARMED);
    assign sys_ack   = r_ack;
    assign sys_rdata = r_rdata;

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [31:0] r_timeout, r_tmoCnt;
    logic        r_tmo;

    assign w_tmoHit = (r_timeout != 32'd0) && (r_tmoCnt >= r_timeout - 32'd1) && !w_qual;
    assign w_tmo    = r_tmo;
    assign w_unused = ^sys_addr[31:20];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout <= 32'd0;
            r_tmoCnt  <= 32'd0;
            r_tmo     <= 1'b0;
        end else begin
            if (sys_wen && (w_addr == c_ADDR_TMO))
                r_timeout <= sys_wdata;
            if ((r_state == S_ARMED) && (w_nextState == S_ARMED) && !w_qual && !w_arm)
                r_tmoCnt <= r_tmoCnt + 32'd1;
            else
                r_tmoCnt <= 32'd0;
            if (w_arm && ((r_state == S_IDLE) || (r_state == S_ARMED)))
                r_tmo <= 1'b0;
            else if (w_fireByTmo)
                r_tmo <= 1'b1;
        end
    end
`else
    assign w_tmoHit = 1'b0;
    assign w_tmo    = 1'b0;
    assign w_unused = ^{sys_addr[31:20], w_fireByTmo};
`endif

    always_comb begin
        w_nextState = r_state;
        w_fireByTmo = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arm)
                    w_nextState = S_ARMED;
            end
            S_ARMED: begin
                if (w_disarm)
                    w_nextState = S_IDLE;
                else if (w_arm)
                    w_nextState = S_ARMED;
                else if (w_qual && w_reach)
                    w_nextState = S_FIRE;
                else if (w_tmoHit) begin
                    w_nextState = S_FIRE;
                    w_fireByTmo = 1'b1;
                end
            end
            S_FIRE: begin
                w_nextState = w_disarm ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (w_disarm)
                    w_nextState = S_IDLE;
                else if (r_holdCnt == '0)
                    w_nextState = r_cont ? S_ARMED : S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_matchCfg  <= CNT_W'(1);
            r_holdoff   <= '0;
            r_cont      <= 1'b0;
            r_consec    <= 1'b0;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_holdCnt   <= '0;
            r_fireCount <= 32'd0;
        end else begin
            r_state <= w_nextState;
            if (w_ctrlWr) begin
                r_cont   <= sys_wdata[2];
                r_consec <= sys_wdata[3];
            end
            if (sys_wen && (w_addr == c_ADDR_MATCH))
                r_matchCfg <= sys_wdata[CNT_W-1:0];
            if (sys_wen && (w_addr == c_ADDR_HOLD))
                r_holdoff <= sys_wdata[HOLD_W-1:0];

            case (r_state)
                S_IDLE: begin
                    if (w_disarm)
                        r_count <= '0;
                    else if (w_arm) begin
                        r_count <= '0;
                        r_done  <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (w_disarm || w_arm)
                        r_count <= '0;
                    else if (w_qual)
                        r_count <= w_cntInc[CNT_W-1:0];
                    else if (trg_valid && !trg_in && r_consec)
                        r_count <= '0;
                end
                S_FIRE: begin
                    r_fireCount <= r_fireCount + 32'd1;
                    r_holdCnt   <= r_holdoff;
                    if (w_disarm)
                        r_count <= '0;
                end
                S_HOLD: begin
                    if (w_disarm)
                        r_count <= '0;
                    else if (r_holdCnt == '0) begin
                        if (r_cont)
                            r_count <= '0;
                        else
                            r_done <= 1'b1;
                    end else
                        r_holdCnt <= r_holdCnt - HOLD_W'(1);
                end
                default: r_count <= '0;
            endcase
        end
    end

    always_comb begin
        w_rdMux = 32'd0;
        case (w_addr)
            c_ADDR_CTRL:   w_rdMux = {28'd0, r_consec, r_cont, 2'b00};
            c_ADDR_MATCH:  w_rdMux = 32'(r_matchCfg);
            c_ADDR_HOLD:   w_rdMux = 32'(r_holdoff);
            c_ADDR_STATUS: w_rdMux = {w_cntExt[15:0], 12'd0, w_tmo, r_done, r_state};
            c_ADDR_FIRES:  w_rdMux = r_fireCount;
`ifdef SPI_SEQ_TIMEOUT_EN
            c_ADDR_TMO:    w_rdMux = r_timeout;
`endif
            default:       w_rdMux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack   <= (sys_wen || sys_ren) && w_inRange;
            r_rdata <= (sys_ren && w_inRange) ? w_rdMux : 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_trig_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_trig_seq
// Brief    : Self-checking bench for spi_trig_seq: register table, directed
//            sequences and a randomized run against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_trig_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sys_addr, sys_wdata, sys_rdata;
    logic        sys_wen, sys_ren, sys_ack;
    logic        trg_in, trg_valid, trig_out, armed;

    always #5 clk = ~clk;

    spi_trig_seq #(.CNT_W(16), .HOLD_W(32)) dut (
        .clk(clk), .rst(rst),
        .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
        .sys_rdata(sys_rdata), .sys_ack(sys_ack),
        .trg_in(trg_in), .trg_valid(trg_valid), .trig_out(trig_out), .armed(armed)
    );

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam logic [31:0] c_TMO_RB    = 32'h55;
    localparam logic [31:0] c_FIRES_EXP = 32'd6;
`else
    localparam logic [31:0] c_TMO_RB    = 32'h0;
    localparam logic [31:0] c_FIRES_EXP = 32'd5;
`endif

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        expAck;
        logic [31:0] expData;
    } vec_t;

    vec_t tbl[$];
    int   nVec = 0;
    int   nMis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addV(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic ea, input logic [31:0] ed);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.expAck = ea; v.expData = ed;
        tbl.push_back(v);
    endtask

    task automatic busWr(input logic [31:0] a, input logic [31:0] d);
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        tick();
        sys_wen = 1'b0;
        chk("wr_ack", 32'(sys_ack), 32'd1);
    endtask

    task automatic rdChk(input string name, input logic [31:0] a, input logic [31:0] exp);
        sys_addr = a; sys_ren = 1'b1;
        tick();
        sys_ren = 1'b0;
        chk({name, "_ack"}, 32'(sys_ack), 32'd1);
        chk(name, sys_rdata, exp);
    endtask

    task automatic strobe(input logic v);
        trg_valid = 1'b1; trg_in = v;
        tick();
        trg_valid = 1'b0; trg_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, pulses;
        bit  got;
        logic [31:0] fc0;

        rst = 1'b1; sys_addr = 0; sys_wdata = 0; sys_wen = 0; sys_ren = 0;
        trg_in = 0; trg_valid = 0;
        tick(); tick();
        chk("rst_trig", 32'(trig_out), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_ack", 32'(sys_ack), 32'd0);
        chk("rst_rdata", sys_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // register map table: reset values, readback, decode range, ack timing
        addV(0, 32'h78, 0, 1, 32'h1);
        addV(0, 32'h7C, 0, 1, 32'h0);
        addV(0, 32'h80, 0, 1, 32'h0);
        addV(0, 32'h84, 0, 1, 32'h0);
        addV(0, 32'h74, 0, 1, 32'h0);
        addV(1, 32'h78, 32'h5, 1, 0);
        addV(0, 32'hABC00078, 0, 1, 32'h5);
        addV(1, 32'h7C, 32'hDEADBEEF, 1, 0);
        addV(0, 32'h7C, 0, 1, 32'hDEADBEEF);
        addV(1, 32'h74, 32'hC, 1, 0);
        addV(0, 32'h74, 0, 1, 32'hC);
        addV(1, 32'h74, 32'h0, 1, 0);
        addV(0, 32'h76, 0, 1, 32'h0);
        addV(0, 32'h90, 0, 0, 0);
        addV(0, 32'h70, 0, 0, 0);
        addV(1, 32'h8C, 32'h1, 0, 0);
        addV(1, 32'h88, 32'h55, 1, 0);
        addV(0, 32'h88, 0, 1, c_TMO_RB);
        addV(1, 32'h88, 32'h0, 1, 0);
        addV(1, 32'h78, 32'h1, 1, 0);
        addV(1, 32'h7C, 32'h0, 1, 0);
        foreach (tbl[i]) begin
            sys_addr = tbl[i].addr; sys_wdata = tbl[i].data;
            sys_wen = tbl[i].wr; sys_ren = !tbl[i].wr;
            tick();
            sys_wen = 1'b0; sys_ren = 1'b0;
            chk($sformatf("tbl%0d_ack", i), 32'(sys_ack), 32'(tbl[i].expAck));
            if (!tbl[i].wr && tbl[i].expAck)
                chk($sformatf("tbl%0d_rdata", i), sys_rdata, tbl[i].expData);
            tick();
            chk($sformatf("tbl%0d_ack_once", i), 32'(sys_ack), 32'd0);
        end

        // single-shot, fire on 3rd match
        busWr(32'h78, 3);
        busWr(32'h74, 32'h1);
        chk("s2_armed", 32'(armed), 32'd1);
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1);
            chk($sformatf("s2_trig%0d", i), 32'(trig_out), 32'(i == 2));
        end
        tick();
        chk("s2_pulse_end", 32'(trig_out), 32'd0);
        tick();
        rdChk("s2_status", 32'h80, 32'h0003_0004);
        rdChk("s2_fires", 32'h84, 32'd1);

        // consecutive mode: 1,0,1,1 with MATCH_CNT=2
        busWr(32'h74, 32'h8);
        busWr(32'h78, 2);
        busWr(32'h74, 32'h9);
        strobe(1'b1); chk("s3_t1", 32'(trig_out), 32'd0);
        strobe(1'b0); chk("s3_t2", 32'(trig_out), 32'd0);
        strobe(1'b1); chk("s3_t3", 32'(trig_out), 32'd0);
        rdChk("s3_status", 32'h80, 32'h0001_0001);
        strobe(1'b1); chk("s3_t4", 32'(trig_out), 32'd1);
        tick(); tick();

        // continuous mode with holdoff 10: strobes at 0, 5, 20
        busWr(32'h7C, 10);
        busWr(32'h78, 1);
        busWr(32'h74, 32'h5);
        for (int k = 0; k < 25; k++) begin
            trg_valid = (k == 0 || k == 5 || k == 20); trg_in = 1'b1;
            tick();
            trg_valid = 1'b0;
            chk($sformatf("s4_trig_c%0d", k + 1), 32'(trig_out), 32'(k == 0 || k == 20));
        end
        busWr(32'h74, 32'h2);
        tick();
        rdChk("s4_fires", 32'h84, 32'd4);
        busWr(32'h7C, 0);

        // disarm while armed with count 2, then a match is ignored
        busWr(32'h78, 3);
        busWr(32'h74, 32'h1);
        strobe(1'b1); strobe(1'b1);
        rdChk("s5_status_pre", 32'h80, 32'h0002_0001);
        busWr(32'h74, 32'h3);
        chk("s5_armed", 32'(armed), 32'd0);
        strobe(1'b1);
        chk("s5_trig", 32'(trig_out), 32'd0);
        rdChk("s5_status", 32'h80, 32'h0000_0000);

        // ARM while armed restarts the count
        busWr(32'h74, 32'h1);
        strobe(1'b1); strobe(1'b1);
        busWr(32'h74, 32'h1);
        strobe(1'b1); chk("rs_t1", 32'(trig_out), 32'd0);
        strobe(1'b1); chk("rs_t2", 32'(trig_out), 32'd0);
        strobe(1'b1); chk("rs_t3", 32'(trig_out), 32'd1);
        tick(); tick();

`ifdef SPI_SEQ_TIMEOUT_EN
        busWr(32'h88, 100);
        busWr(32'h74, 32'h1);
        n = 0; got = 0;
        for (int k = 1; k <= 200 && !got; k++) begin
            tick();
            if (trig_out) begin got = 1; n = k; end
        end
        chk("tmo_latency_99_101", 32'(got && n >= 99 && n <= 101), 32'd1);
        tick(); tick();
        rdChk("tmo_status", 32'h80, 32'h0000_000C);
        busWr(32'h88, 0);
        busWr(32'h74, 32'h1);
        rdChk("tmo_cleared", 32'h80, 32'h0000_0001);
        busWr(32'h74, 32'h2);
`else
        busWr(32'h74, 32'h1);
        pulses = 0;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (trig_out) pulses++;
        end
        chk("notmo_pulses", 32'(pulses), 32'd0);
        rdChk("notmo_status", 32'h80, 32'h0000_0001);
        busWr(32'h74, 32'h2);
`endif
        rdChk("fires_total", 32'h84, c_FIRES_EXP);

        // asynchronous reset truncates a pulse in flight
        busWr(32'h78, 7);
        busWr(32'h78, 1);
        busWr(32'h74, 32'h1);
        strobe(1'b1);
        chk("rm_trig_pre", 32'(trig_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("rm_trig", 32'(trig_out), 32'd0);
        chk("rm_armed", 32'(armed), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        rdChk("rm_match", 32'h78, 32'd1);
        rdChk("rm_fires", 32'h84, 32'd0);
        rdChk("rm_status", 32'h80, 32'd0);

        // randomized rounds vs. an event-level model: a fire at sample j blocks
        // strobes until j+HOLDOFF+3 (continuous) or forever (single-shot)
        for (int r = 0; r < 4; r++) begin
            int mc, h, rearm, cnt, fires;
            bit cont, consec;
            mc = $urandom_range(0, 4);
            h = $urandom_range(0, 6);
            cont = 1'($urandom_range(0, 1));
            consec = 1'($urandom_range(0, 1));
            busWr(32'h78, 32'(mc));
            busWr(32'h7C, 32'(h));
            sys_addr = 32'h84; sys_ren = 1'b1; tick(); sys_ren = 1'b0;
            fc0 = sys_rdata;
            busWr(32'h74, {28'd0, consec, cont, 2'b01});
            rearm = 0; cnt = 0; fires = 0;
            for (int j = 0; j < 200; j++) begin
                bit v, b, fire;
                v = ($urandom_range(0, 2) == 0);
                b = 1'($urandom_range(0, 1));
                fire = 0;
                if (v && j >= rearm) begin
                    if (b) begin
                        cnt++;
                        if (cnt >= ((mc == 0) ? 1 : mc)) begin
                            fire = 1; fires++; cnt = 0;
                            rearm = cont ? j + h + 3 : (1 << 30);
                        end
                    end else if (consec)
                        cnt = 0;
                end
                trg_valid = v; trg_in = b;
                tick();
                trg_valid = 1'b0;
                chk($sformatf("rnd%0d_trig_%0d", r, j), 32'(trig_out), 32'(fire));
                chk($sformatf("rnd%0d_armed_%0d", r, j), 32'(armed), 32'(j >= rearm - 1));
            end
            busWr(32'h74, 32'h2);
            tick(); tick();
            rdChk($sformatf("rnd%0d_fires", r), 32'h84, fc0 + 32'(fires));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
